// File: rtl/h_loader.sv
// ---------------------------------------------------------------------------
// h_loader
//
// Serial-to-parallel frame loader feeding pre_process. Signed WIDTH-bit
// samples arrive one per accepted valid/ready beat and are assembled into
// sixteen channel vectors (H1..H16) followed by one receive vector (y_in),
// each DIMENSION elements wide. Element k of a vector sits at bits
// [k*WIDTH +: WIDTH], so element 0 is at the LSB. Once the last element of
// y_in lands, the loader stops accepting samples and holds en high until
// the downstream block acknowledges the frame.
//
// Optional feature macro: H_LOADER_LAST_CHK_EN
//   When defined, adds the s_last input and the sticky frame_err output,
//   and checks that s_last marks exactly the final beat of every frame.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous, active-low reset
//   s_valid    input sample valid
//   s_ready    loader can accept a sample (high in LOAD)
//   s_data     signed input sample, stored unmodified
//   s_last     end-of-frame marker (H_LOADER_LAST_CHK_EN only)
//   frame_err  sticky framing error (H_LOADER_LAST_CHK_EN only)
//   en         frame complete, held until ack
//   ack        downstream has consumed the frame (ignored in LOAD)
//   H1..H16    assembled channel vectors
//   y_in       assembled receive vector
// ---------------------------------------------------------------------------
module h_loader #(
  parameter int DIMENSION = 256,
  parameter int WIDTH     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic signed [WIDTH-1:0]     s_data,
`ifdef H_LOADER_LAST_CHK_EN
  input  logic                        s_last,
  output logic                        frame_err,
`endif
  output logic                        en,
  input  logic                        ack,
  output logic [DIMENSION*WIDTH-1:0]  H1,
  output logic [DIMENSION*WIDTH-1:0]  H2,
  output logic [DIMENSION*WIDTH-1:0]  H3,
  output logic [DIMENSION*WIDTH-1:0]  H4,
  output logic [DIMENSION*WIDTH-1:0]  H5,
  output logic [DIMENSION*WIDTH-1:0]  H6,
  output logic [DIMENSION*WIDTH-1:0]  H7,
  output logic [DIMENSION*WIDTH-1:0]  H8,
  output logic [DIMENSION*WIDTH-1:0]  H9,
  output logic [DIMENSION*WIDTH-1:0]  H10,
  output logic [DIMENSION*WIDTH-1:0]  H11,
  output logic [DIMENSION*WIDTH-1:0]  H12,
  output logic [DIMENSION*WIDTH-1:0]  H13,
  output logic [DIMENSION*WIDTH-1:0]  H14,
  output logic [DIMENSION*WIDTH-1:0]  H15,
  output logic [DIMENSION*WIDTH-1:0]  H16,
  output logic [DIMENSION*WIDTH-1:0]  y_in
);

  localparam int VEC_BITS = DIMENSION * WIDTH;
  // A one-element vector still needs a one-bit counter to keep ports legal.
  localparam int ELEM_W   = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;
  localparam logic [ELEM_W-1:0] ELEM_LAST = ELEM_W'(DIMENSION - 1);
  // Vector slot 16 is y_in; slots 0..15 are H1..H16.
  localparam logic [4:0] VEC_LAST = 5'd16;

  typedef enum logic {
    LOAD = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [ELEM_W-1:0]   elem_cnt;
  logic [4:0]          vec_cnt;
  logic [VEC_BITS-1:0] vecs [17];
  logic                accept;
  logic                last_beat;
  logic                beat_err;

  assign accept    = s_valid && s_ready;
  assign last_beat = (vec_cnt == VEC_LAST) && (elem_cnt == ELEM_LAST);

  // A framing error is an accepted beat whose s_last disagrees with the
  // beat counters; without the checker every beat is taken at face value.
`ifdef H_LOADER_LAST_CHK_EN
  assign beat_err = accept && (s_last != last_beat);
`else
  assign beat_err = 1'b0;
`endif

  // Handshake outputs are pure decodes of the state register, so s_ready
  // has no combinational path from s_valid.
  assign s_ready = (state == LOAD);
  assign en      = (state == HOLD);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LOAD;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: a good final beat completes the frame; ack releases
  // it. A bad final beat keeps us in LOAD so the frame is discarded.
  always_comb begin
    next_state = state;
    case (state)
      LOAD: begin
        if (accept && last_beat && !beat_err) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (ack) begin
          next_state = LOAD;
        end
      end
      default: begin
        next_state = LOAD;
      end
    endcase
  end

  // Element/vector counters. Both clear at the end of a frame and on any
  // framing error, so the next accepted beat is always H1 element 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      elem_cnt <= '0;
      vec_cnt  <= '0;
    end else if (accept) begin
      if (last_beat || beat_err) begin
        elem_cnt <= '0;
        vec_cnt  <= '0;
      end else if (elem_cnt == ELEM_LAST) begin
        elem_cnt <= '0;
        vec_cnt  <= vec_cnt + 5'd1;
      end else begin
        elem_cnt <= elem_cnt + 1'b1;
      end
    end
  end

  // Frame storage. Each accepted beat overwrites exactly one element; the
  // rest keep their old contents, which is harmless since en is low while
  // loading. Nothing is written in HOLD because s_ready is low there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < 17; v++) begin
        vecs[v] <= '0;
      end
    end else if (accept) begin
      vecs[vec_cnt][elem_cnt*WIDTH +: WIDTH] <= s_data;
    end
  end

`ifdef H_LOADER_LAST_CHK_EN
  // Sticky framing error flag; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err <= 1'b0;
    end else if (beat_err) begin
      frame_err <= 1'b1;
    end
  end
`endif

  assign H1   = vecs[0];
  assign H2   = vecs[1];
  assign H3   = vecs[2];
  assign H4   = vecs[3];
  assign H5   = vecs[4];
  assign H6   = vecs[5];
  assign H7   = vecs[6];
  assign H8   = vecs[7];
  assign H9   = vecs[8];
  assign H10  = vecs[9];
  assign H11  = vecs[10];
  assign H12  = vecs[11];
  assign H13  = vecs[12];
  assign H14  = vecs[13];
  assign H15  = vecs[14];
  assign H16  = vecs[15];
  assign y_in = vecs[16];

endmodule

// File: doc/h_loader.md
# h_loader

Serial-to-parallel frame loader that feeds `pre_process`. It accepts a stream of signed WIDTH-bit samples over a valid/ready handshake. It assembles one frame of 16 channel vectors (H1..H16) and one receive vector (y), each DIMENSION elements wide. It then presents the frame on wide parallel buses, with `en` held until the downstream block acknowledges, and only then accepts the next frame.

## Interface
- Parameters:
- DIMENSION, 256, elements per vector
- WIDTH, 8, bits per element (signed two's complement)
- Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- s_valid  in  1  input sample valid
- s_ready  out  1  loader can accept a sample
- s_data  in  WIDTH  signed input sample
- s_last  in  1  end-of-frame marker; present only with H_LOADER_LAST_CHK_EN
- en  out  1  frame complete; drives `pre_process` en
- ack  in  1  downstream has consumed the frame
- H1..H16  out  DIMENSION*WIDTH each  assembled channel vectors
- y_in  out  DIMENSION*WIDTH  assembled receive vector
- frame_err  out  1  sticky framing error; present only with H_LOADER_LAST_CHK_EN

## Operation
- A beat is accepted when s_valid && s_ready are both high at a rising edge.
- Frame order is H1 elements 0..DIMENSION-1, then H2, and so on through H16, then y: 17*DIMENSION beats in total.
- Element k of a vector occupies bits [k*WIDTH +: WIDTH], so element 0 is at the LSB. Data is stored unmodified, with no sign extension or scaling.
- Counters:
  - elem_cnt runs 0..DIMENSION-1 and wraps to 0 with a vec_cnt increment.
  - vec_cnt runs 0..16, where 16 selects y.
- FSM states:
  - LOAD: s_ready=1, en=0. Every accepted beat writes exactly one element. On the accepted beat with vec_cnt=16 and elem_cnt=DIMENSION-1, go to HOLD and clear both counters.
  - HOLD: s_ready=0, en=1. The H*/y_in registers are frozen. When ack=1, go to LOAD at the next edge.
- ack is ignored in LOAD.
- s_valid is ignored in HOLD because s_ready=0 there.
- Reset:
  - Asserting rst (low) at any time forces LOAD and clears both counters, en, and frame_err.
  - All H1..H16 and y_in are cleared to 0 and s_ready=1 after release.
  - A partially loaded frame is discarded.
- Registers not yet overwritten in a new frame keep the previous frame's values. This is harmless because en=0 during LOAD.

## Timing
- s_ready is a registered state decode with no combinational path from s_valid.
- Latency: the final beat is accepted at edge N; en=1 and the complete buses are valid from just after edge N. s_ready drops at that same edge.
- If ack=1 at edge M in HOLD, then en=0 and s_ready=1 after edge M. The first beat of the next frame can be accepted at edge M+1.
- Peak throughput is one beat per cycle. Minimum frame period is 17*DIMENSION+1 cycles, with ack tied high.

## Configuration
- Macro H_LOADER_LAST_CHK_EN. When defined, the s_last and frame_err ports exist.
- With the macro, an accepted beat is a framing error in either of these cases:
  - s_last=1 on any beat other than the final one.
  - s_last=0 on the final beat.
- On a framing error:
  - frame_err is set and stays high until reset.
  - Both counters clear and the FSM stays in LOAD, so the frame is discarded and en is not raised.
  - The next accepted beat is treated as H1 element 0.
- Without the macro, s_last and frame_err are absent and framing relies on beat count only.

## Test plan
- DIMENSION=4, WIDTH=8; stream 68 beats with values 0..67 and s_valid held high -> after beat 68, en=1, s_ready=0, H1=32'h03020100, H16=32'h3F3E3D3C, y_in=32'h43424140.
- Hold ack=0 for 10 cycles in HOLD while s_valid=1 -> buses unchanged, no beat accepted. Pulse ack=1 -> the next cycle has en=0, s_ready=1, and the next beat lands in H1[7:0].
- Insert random s_valid gaps using value 8'h80 (-128) -> the same final bus contents as the gapless run, with negative values stored as 8'h80.
- Assert rst low after 30 beats, release, then send a full frame 100..167 -> en rises only after 68 new beats, and H1=32'h67666564.
- With H_LOADER_LAST_CHK_EN: s_last=1 on beat 5 -> frame_err=1 and en stays 0. A following correct 68-beat frame gives en=1 while frame_err stays 1.
- With H_LOADER_LAST_CHK_EN: s_last=0 on beat 68 -> frame_err=1 and no en.
